// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, keeps one imem request in flight at a time and hands instructions to decode.
// Latency: a response in cycle N gives inst_valid in cycle N+1; the next request goes out the cycle after decode accepts.
// Backpressure: the request is held until imem_req_ready (its address follows redirects); the instruction is held until inst_ready.
// Build option FETCH_MISALIGN_CHK_EN: adds fetch_misalign and a HALT state entered on a misaligned redirect target.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            fetch_misalign,
`endif
    output logic [XLEN-1:0] pc_o
);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;
`endif

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_drop;      // the in-flight response belongs to a squashed fetch
    logic            r_req_vld;
    logic            r_inst_vld;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;

    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + XLEN'(4);

`ifdef FETCH_MISALIGN_CHK_EN
    logic            r_misalign;
    logic            w_redir_bad;
    logic            w_pending_nxt;

    // Misaligned targets are loaded as-is so the faulting PC stays visible.
    assign w_redir_pc  = redirect_pc;
    assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Whether a request will still be awaiting its response after this edge.
    always_comb begin
        w_pending_nxt = 1'b0;
        case (r_state)
            ST_REQ:  w_pending_nxt = imem_req_ready;
            ST_WAIT: w_pending_nxt = !imem_resp_valid;
            ST_HALT: w_pending_nxt = r_drop && !imem_resp_valid;
            default: w_pending_nxt = 1'b0;
        endcase
    end

    assign fetch_misalign = r_misalign;
`else
    // Without the checker, the low two target bits are simply dropped.
    assign w_redir_pc = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    // Fetch FSM: state, PC, drop flag and every registered output advance together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_req_vld  <= 1'b0;
            r_inst_vld <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                // One idle cycle out of reset; responses seen here are leftovers and ignored.
                ST_BOOT: begin
                    if (redirect_valid) r_pc <= w_redir_pc;
                    r_state   <= ST_REQ;
                    r_req_vld <= 1'b1;
                end
                // Request on the bus; a redirect before acceptance just retargets it.
                ST_REQ: begin
                    if (redirect_valid) r_pc <= w_redir_pc;
                    if (imem_req_ready) begin
                        r_state   <= ST_WAIT;
                        r_req_vld <= 1'b0;
                        r_drop    <= redirect_valid;
                    end
                end
                // Awaiting the single outstanding response.
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        r_drop <= 1'b0;
                        if (r_drop || redirect_valid) begin
                            if (redirect_valid) r_pc <= w_redir_pc;
                            r_state   <= ST_REQ;
                            r_req_vld <= 1'b1;
                        end else begin
                            r_inst     <= imem_resp_data;
                            r_inst_pc  <= r_pc;
                            r_pc       <= w_pc_inc;
                            r_state    <= ST_HOLD;
                            r_inst_vld <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        r_drop <= 1'b1;
                        r_pc   <= w_redir_pc;
                    end
                end
                // Instruction offered to decode; a redirect squashes it even if accepted.
                ST_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        if (redirect_valid) r_pc <= w_redir_pc;
                        r_state    <= ST_REQ;
                        r_req_vld  <= 1'b1;
                        r_inst_vld <= 1'b0;
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                // Parked after a misaligned redirect; swallow any stale response.
                ST_HALT: begin
                    if (imem_resp_valid) r_drop <= 1'b0;
                    if (redirect_valid) begin
                        r_pc       <= w_redir_pc;
                        r_misalign <= 1'b0;
                        // A stale response still in flight must drain before the next request.
                        if (r_drop && !imem_resp_valid) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state   <= ST_REQ;
                            r_req_vld <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= ST_BOOT;
                    r_req_vld  <= 1'b0;
                    r_inst_vld <= 1'b0;
                end
            endcase
`ifdef FETCH_MISALIGN_CHK_EN
            // A misaligned redirect overrides whatever the state logic chose.
            if (w_redir_bad) begin
                r_pc       <= redirect_pc;
                r_misalign <= 1'b1;
                r_state    <= ST_HALT;
                r_req_vld  <= 1'b0;
                r_inst_vld <= 1'b0;
                r_drop     <= w_pending_nxt;
            end
`endif
        end
    end

    assign imem_req_valid = r_req_vld;
    assign imem_req_addr  = r_pc;
    assign pc_o           = r_pc;
    assign inst_valid     = r_inst_vld;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand-written corner sequences, then random traffic vs a transaction-level model.
// Latency: inputs applied 1 time unit after a rising edge, outputs compared 1 time unit after the following edge.
// Backpressure: memory ready, response delay (1-3 cycles) and decode ready are all randomized in the last phase.
module tb_fetch_sequencer;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_pc;
    logic [31:0] inst;
    logic [63:0] pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    always #5 clock = ~clock;

    fetch_sequencer #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst           (inst),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .pc_o           (pc_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        rsp;
        logic [31:0] dat;
        logic        irdy;
        logic        e_req;
        logic        e_ivld;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic [63:0] e_ipc;
    } vec_t;

    vec_t tbl[$];

    // Transaction-level reference state for the random phase.
    logic [63:0] m_pc;
    logic        m_out;
    logic [63:0] m_out_addr;
    logic        m_stale;
    logic        m_hold;
    logic [63:0] m_hold_pc;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic        t_redir;
    logic [63:0] t_rpc;
    logic        t_rdy;
    logic        t_rsp;
    logic [31:0] t_dat;
    logic        t_irdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic redir, input logic [63:0] rpc, input logic rdy,
                          input logic rsp, input logic [31:0] dat, input logic irdy);
        redirect_valid  = redir;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = dat;
        inst_ready      = irdy;
    endtask

    function automatic vec_t mk(input logic redir, input logic [63:0] rpc, input logic rdy,
                                input logic rsp, input logic [31:0] dat, input logic irdy,
                                input logic e_req, input logic e_ivld, input logic [63:0] e_pc,
                                input logic [31:0] e_ins, input logic [63:0] e_ipc);
        vec_t v;
        v = '{redir, rpc, rdy, rsp, dat, irdy, e_req, e_ivld, e_pc, e_ins, e_ipc};
        return v;
    endfunction

    // Memory image: instruction word is a fixed function of its address.
    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] align4(input logic [63:0] a);
        return {a[63:2], 2'b00};
    endfunction

    initial begin
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- reset state ----------------
        step(); step(); step();
        chk("reset req_vld",    imem_req_valid, 1'b0);
        chk("reset inst_valid", inst_valid,     1'b0);
        chk("reset pc",         pc_o,           RESET_PC);
        chk("reset inst",       inst,           32'h0);
        chk("reset inst_pc",    inst_pc,        64'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("reset misalign",   fetch_misalign, 1'b0);
`endif

        // ---------------- directed vector table ----------------
        //          redir rpc                     rdy  rsp  dat            irdy | req  ivld pc                      inst           inst_pc
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    1,   0,   64'h8000_0000, 32'h0,         64'h0));
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    0,   0,   64'h8000_0000, 32'h0,         64'h0));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'h0000_0013, 1,    0,   1,   64'h8000_0004, 32'h0000_0013, 64'h8000_0000));
        tbl.push_back(mk(0, 64'h0,                 0,   0,   32'h0,         1,    1,   0,   64'h8000_0004, 32'h0000_0013, 64'h8000_0000));
        tbl.push_back(mk(0, 64'h0,                 0,   0,   32'h0,         1,    1,   0,   64'h8000_0004, 32'h0000_0013, 64'h8000_0000));
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    0,   0,   64'h8000_0004, 32'h0000_0013, 64'h8000_0000));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'h0010_0093, 0,    0,   1,   64'h8000_0008, 32'h0010_0093, 64'h8000_0004));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 64'h0,             1,   0,   32'h0,         0,    0,   1,   64'h8000_0008, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 0,   0,   32'h0,         1,    1,   0,   64'h8000_0008, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    0,   0,   64'h8000_0008, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(1, 64'h8000_1000,         0,   0,   32'h0,         1,    0,   0,   64'h8000_1000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 0,   0,   32'h0,         1,    0,   0,   64'h8000_1000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'hDEAD_BEEF, 1,    1,   0,   64'h8000_1000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(1, 64'h8000_2000,         1,   0,   32'h0,         1,    0,   0,   64'h8000_2000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'hBAD0_0000, 1,    1,   0,   64'h8000_2000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    0,   0,   64'h8000_2000, 32'h0010_0093, 64'h8000_0004));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'h0000_0513, 1,    0,   1,   64'h8000_2004, 32'h0000_0513, 64'h8000_2000));
        tbl.push_back(mk(1, 64'h8000_3000,         0,   0,   32'h0,         0,    1,   0,   64'h8000_3000, 32'h0000_0513, 64'h8000_2000));
        tbl.push_back(mk(1, 64'h8000_4000,         0,   0,   32'h0,         1,    1,   0,   64'h8000_4000, 32'h0000_0513, 64'h8000_2000));
        tbl.push_back(mk(0, 64'h0,                 1,   0,   32'h0,         1,    0,   0,   64'h8000_4000, 32'h0000_0513, 64'h8000_2000));
        tbl.push_back(mk(0, 64'h0,                 0,   1,   32'h00a0_0593, 1,    0,   1,   64'h8000_4004, 32'h00a0_0593, 64'h8000_4000));
        tbl.push_back(mk(1, 64'h8000_5000,         0,   0,   32'h0,         1,    1,   0,   64'h8000_5000, 32'h00a0_0593, 64'h8000_4000));

        reset = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rsp, tbl[i].dat, tbl[i].irdy);
            step();
            chk($sformatf("row%0d req_vld", i),    imem_req_valid, tbl[i].e_req);
            chk($sformatf("row%0d req_addr", i),   imem_req_addr,  tbl[i].e_pc);
            chk($sformatf("row%0d inst_valid", i), inst_valid,     tbl[i].e_ivld);
            chk($sformatf("row%0d pc", i),         pc_o,           tbl[i].e_pc);
            chk($sformatf("row%0d inst", i),       inst,           tbl[i].e_ins);
            chk($sformatf("row%0d inst_pc", i),    inst_pc,        tbl[i].e_ipc);
        end

        // ---------------- PC wrap at the top of the address space ----------------
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("wrap retarget pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        set_in(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        chk("wrap accepted", imem_req_valid, 1'b0);
        set_in(1'b0, 64'h0, 1'b0, 1'b1, 32'h0000_0073, 1'b1);
        step();
        chk("wrap pc",         pc_o,       64'h0);
        chk("wrap inst_pc",    inst_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap inst",       inst,       32'h0000_0073);
        chk("wrap inst_valid", inst_valid, 1'b1);
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("wrap next req",  imem_req_valid, 1'b1);
        chk("wrap next addr", imem_req_addr,  64'h0);

        // ---------------- misaligned redirect target ----------------
`ifdef FETCH_MISALIGN_CHK_EN
        set_in(1'b1, 64'h8000_0002, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("halt misalign", fetch_misalign, 1'b1);
        chk("halt req_vld",  imem_req_valid, 1'b0);
        chk("halt pc",       pc_o,           64'h8000_0002);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1);
            step();
            chk($sformatf("halt idle%0d req_vld", k), imem_req_valid, 1'b0);
            chk($sformatf("halt idle%0d inst_vld", k), inst_valid,    1'b0);
            chk($sformatf("halt idle%0d misalign", k), fetch_misalign, 1'b1);
        end
        set_in(1'b1, 64'h8000_0100, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("unhalt misalign", fetch_misalign, 1'b0);
        chk("unhalt req_vld",  imem_req_valid, 1'b1);
        chk("unhalt addr",     imem_req_addr,  64'h8000_0100);
`else
        set_in(1'b1, 64'h8000_0102, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("masked redirect pc", pc_o, 64'h8000_0100);
        chk("masked redirect req", imem_req_valid, 1'b1);
`endif

        // ---------------- reset mid-flight; leftover response during BOOT ----------------
        set_in(1'b0, 64'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        chk("pre-abort waiting", imem_req_valid, 1'b0);
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("abort req_vld", imem_req_valid, 1'b0);
        chk("abort pc",      pc_o,           RESET_PC);
        chk("abort inst",    inst,           32'h0);
        chk("abort inst_pc", inst_pc,        64'h0);
        reset = 1'b0;
        set_in(1'b0, 64'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        step();
        chk("boot resp ignored ivld", inst_valid,     1'b0);
        chk("boot resp ignored req",  imem_req_valid, 1'b1);
        chk("boot resp ignored pc",   pc_o,           RESET_PC);

        // ---------------- redirect during BOOT ----------------
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        reset = 1'b0;
        set_in(1'b1, 64'h8000_7000, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("boot redirect req",  imem_req_valid, 1'b1);
        chk("boot redirect addr", imem_req_addr,  64'h8000_7000);

        // ---------------- random traffic vs reference model ----------------
        reset = 1'b1;
        set_in(1'b0, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        step();
        m_pc = RESET_PC; m_out = 1'b0; m_out_addr = '0; m_stale = 1'b0;
        m_hold = 1'b0; m_hold_pc = '0; mem_cnt = 0; mem_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd req_vld",    imem_req_valid, !m_out && !m_hold);
            chk("rnd inst_valid", inst_valid,     m_hold);
            chk("rnd pc",         pc_o,           m_pc);
            chk("rnd req_addr",   imem_req_addr,  m_pc);
            if (m_hold) begin
                chk("rnd inst",    inst,    memf(m_hold_pc));
                chk("rnd inst_pc", inst_pc, m_hold_pc);
            end
            t_redir = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) t_rpc = align4({$urandom, $urandom});
            else                           t_rpc = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
            t_rdy  = 1'($urandom_range(0, 1));
            t_irdy = ($urandom_range(0, 2) != 0);
            t_rsp  = (mem_cnt == 1);
            t_dat  = t_rsp ? memf(mem_addr) : $urandom;
            set_in(t_redir, t_rpc, t_rdy, t_rsp, t_dat, t_irdy);

            // memory: one response, 1-3 cycles after each accepted request
            if (mem_cnt != 0) mem_cnt--;
            if (imem_req_valid && t_rdy) begin
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = imem_req_addr;
            end

            // reference: one fetch in flight; a redirect anywhere in its lifetime kills it
            if (m_hold) begin
                if (t_redir) begin m_hold = 1'b0; m_pc = align4(t_rpc); end
                else if (t_irdy) m_hold = 1'b0;
            end else if (!m_out) begin
                if (t_rdy) begin m_out = 1'b1; m_out_addr = m_pc; m_stale = t_redir; end
                if (t_redir) m_pc = align4(t_rpc);
            end else if (t_rsp) begin
                m_out = 1'b0;
                if (m_stale || t_redir) begin
                    if (t_redir) m_pc = align4(t_rpc);
                end else begin
                    m_hold = 1'b1; m_hold_pc = m_out_addr; m_pc = m_out_addr + 64'd4;
                end
            end else if (t_redir) begin
                m_stale = 1'b1; m_pc = align4(t_rpc);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
